// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings and fetch-stage types.
// Used by the instruction fetch stage and its IF/ID pipeline register.
package riscv_pkg;

    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

    localparam logic [6:0]  OPC_OP_IMM   = 7'b001_0011;
    localparam logic [6:0]  OPC_SYSTEM   = 7'b111_0011;

    typedef enum logic [1:0] {
        FS_RUN   = 2'b00,
        FS_DRAIN = 2'b01,
        FS_HALT  = 2'b10
    } fetch_state_e;

    function automatic logic is_halt_instr(input logic [31:0] instr);
        return (instr[6:0] == OPC_SYSTEM) &&
               ((instr == INSTR_EBREAK) || (instr == INSTR_ECALL));
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads the fetched payload or a NOP bubble when enabled.
// A bubble still carries the PC of the slot so downstream stages see a sane address.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        bubble,
    input  logic        valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pc4_q,   pc4_d;

    // Next-payload selection: hold, load fetched word, or insert bubble.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        if (en) begin
            if (bubble) begin
                valid_d = 1'b0;
                instr_d = INSTR_NOP;
            end else begin
                valid_d = valid_i;
                instr_d = instr_i;
            end
            pc_d  = pc_i;
            pc4_d = pc4_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Payload flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= INSTR_NOP;
            pc_q    <= RESET_PC;
            pc4_q   <= RESET_PC + 32'd4;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, redirect/stall/flush handling and the
// RUN/DRAIN/HALT sequence that stops fetch after EBREAK/ECALL or a fetch fault.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_WORDS   = 32,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        ohalt
);

    localparam logic [31:0] FETCH_LIMIT = RESET_PC + 32'(4 * IMEM_WORDS);
    localparam logic [31:0] DRAIN_LOAD  = 32'(DRAIN_CYCLES);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    fetch_state_e state_q, state_d;
    logic         ohalt_q, ohalt_d;
    logic         ifid_en, ifid_bubble;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_tgt;
    logic         fetch_fault;
    logic         unused_redirect_lsb;

    assign pc_plus4            = pc_q + 32'd4;
    assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
    assign fetch_fault         = (pc_q >= FETCH_LIMIT);
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Next-PC / FSM / IF-ID control; a halting instruction freezes PC on itself.
    always_comb begin
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        ohalt_d     = ohalt_q;
        ifid_en     = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            FS_RUN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_tgt;
                    ifid_en     = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (fetch_fault) begin
                    ifid_en     = 1'b1;
                    ifid_bubble = 1'b1;
                    state_d     = FS_DRAIN;
                    cnt_d       = DRAIN_LOAD;
                end else if (flush) begin
                    pc_d        = pc_plus4;
                    ifid_en     = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (is_halt_instr(imem_rdata)) begin
                    ifid_en = 1'b1;
                    state_d = FS_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else begin
                    pc_d    = pc_plus4;
                    ifid_en = 1'b1;
                end
            end
            FS_DRAIN: begin
                if (redirect_valid) begin
                    pc_d        = redirect_tgt;
                    cnt_d       = 32'd0;
                    state_d     = FS_RUN;
                    ifid_en     = 1'b1;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    cnt_d = cnt_q;
                end else begin
                    ifid_en     = 1'b1;
                    ifid_bubble = 1'b1;
                    if (cnt_q <= 32'd1) begin
                        cnt_d   = 32'd0;
                        state_d = FS_HALT;
                        ohalt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
            FS_HALT: begin
                ifid_en     = 1'b1;
                ifid_bubble = 1'b1;
                ohalt_d     = 1'b1;
            end
            default: begin
                state_d     = FS_RUN;
                ifid_en     = 1'b1;
                ifid_bubble = 1'b1;
            end
        endcase
    end

    // PC, FSM state, drain counter and sticky halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            cnt_q   <= 32'd0;
            state_q <= FS_RUN;
            ohalt_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ohalt_q <= ohalt_d;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .en      (ifid_en),
        .bubble  (ifid_bubble),
        .valid_i (1'b1),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .pc4_i   (pc_plus4),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc_o    (if_id_pc),
        .pc4_o   (if_id_pc4)
    );

    assign imem_addr = pc_q;
    assign ohalt     = ohalt_q;

endmodule
